conv_readout: RTL

Readback stage for the 3-tap convolution capture path. Once a capture run finishes, this block reads the stored results back out of the two byte-wide result RAMs. The low-byte RAM is selected by `enout1` and the high-byte RAM by `enout2`; both share one address bus and one 8-bit data bus. The block reassembles each pair of bytes into a 16-bit word, presents it on a valid/ready stream for the host/UART side, and tracks the peak value seen in the run.

---
 rtl/conv_readout_if.sv | 28 ++
 rtl/conv_readout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/conv_readout_if.sv
// Bus bundle for conv_readout: run control, shared RAM read port, result stream and status.
// Stream: a word transfers on every CLK edge where dvalid && dready; dout and dvalid hold until then.
interface conv_readout_if;
  logic        start;
  logic [11:0] count;
  logic [7:0]  ramdata;
  logic [10:0] address;
  logic        rd;
  logic        enout1;
  logic        enout2;
  logic [15:0] dout;
  logic        dvalid;
  logic        dready;
  logic        busy;
  logic        done;
  logic [15:0] peak;
  logic [2:0]  dbg_state;

  modport master (
    input  start, count, ramdata, dready,
    output address, rd, enout1, enout2, dout, dvalid, busy, done, peak, dbg_state
  );

  modport slave (
    output start, count, ramdata, dready,
    input  address, rd, enout1, enout2, dout, dvalid, busy, done, peak, dbg_state
  );
endinterface

// File: rtl/conv_readout.sv
// Reads captured results back from the lo/hi byte RAMs, rebuilds 16-bit words,
// streams them out and tracks the run's peak value.
module conv_readout #(
  parameter int RD_WAIT = 2,
  parameter int DEPTH   = 2048
) (
  input logic            CLK,
  input logic            reset,
  conv_readout_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RDLO  = 3'd2,
    GAP   = 3'd3,
    RDHI  = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [3:0]  WLAST = 4'(RD_WAIT - 1);
  localparam logic [11:0] NMAX  = 12'(DEPTH);

  state_t      state, state_d;
  logic [11:0] idx, idx_d;
  logic [11:0] n, n_d;
  logic [3:0]  cnt, cnt_d;
  logic [7:0]  lo, lo_d;
  logic [10:0] address, address_d;
  logic        rd, rd_d;
  logic        enout1, enout1_d;
  logic        enout2, enout2_d;
  logic [15:0] dout, dout_d;
  logic        dvalid, dvalid_d;
  logic        busy, busy_d;
  logic        done, done_d;
  logic [15:0] peak, peak_d;

  logic [11:0] n_clamp;
  logic [11:0] idx_inc;

  assign n_clamp = (bus.count > NMAX) ? NMAX : bus.count;
  assign idx_inc = idx + 12'd1;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      n       <= '0;
      cnt     <= '0;
      lo      <= '0;
      address <= '0;
      rd      <= 1'b1;
      enout1  <= 1'b1;
      enout2  <= 1'b1;
      dout    <= '0;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      peak    <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      n       <= n_d;
      cnt     <= cnt_d;
      lo      <= lo_d;
      address <= address_d;
      rd      <= rd_d;
      enout1  <= enout1_d;
      enout2  <= enout2_d;
      dout    <= dout_d;
      dvalid  <= dvalid_d;
      busy    <= busy_d;
      done    <= done_d;
      peak    <= peak_d;
    end
  end

  // Strobes are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    n_d       = n;
    cnt_d     = cnt;
    lo_d      = lo;
    address_d = address;
    rd_d      = rd;
    enout1_d  = enout1;
    enout2_d  = enout2;
    dout_d    = dout;
    dvalid_d  = dvalid;
    busy_d    = busy;
    done_d    = 1'b0;
    peak_d    = peak;

    case (state)
      IDLE: begin
        if (bus.start) begin
          n_d    = n_clamp;
          idx_d  = '0;
          peak_d = '0;
          busy_d = 1'b1;
          if (n_clamp == 12'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        address_d = idx[10:0];
        enout1_d  = 1'b0;
        rd_d      = 1'b0;
        cnt_d     = '0;
        state_d   = RDLO;
      end

      RDLO: begin
        if (cnt == WLAST) begin
          lo_d     = bus.ramdata;
          enout1_d = 1'b1;
          rd_d     = 1'b1;
          state_d  = GAP;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end

      // Idle bus cycle between the two chip selects so the RAMs never fight.
      GAP: begin
        enout2_d = 1'b0;
        rd_d     = 1'b0;
        cnt_d    = '0;
        state_d  = RDHI;
      end

      RDHI: begin
        if (cnt == WLAST) begin
          dout_d   = {bus.ramdata, lo};
          dvalid_d = 1'b1;
          enout2_d = 1'b1;
          rd_d     = 1'b1;
          state_d  = OUT;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end

      OUT: begin
        if (dvalid && bus.dready) begin
          dvalid_d = 1'b0;
          peak_d   = (dout > peak) ? dout : peak;
          idx_d    = idx_inc;
          if (idx_inc == n) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.address   = address;
  assign bus.rd        = rd;
  assign bus.enout1    = enout1;
  assign bus.enout2    = enout2;
  assign bus.dout      = dout;
  assign bus.dvalid    = dvalid;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.peak      = peak;
  assign bus.dbg_state = state;

endmodule
